// File: rtl/spi_master_nc_if.sv
// spi_master_nc_if - bus and pin bundle for the spi_master_nc engine.
//
// CPU side (from the port decoder / to the bus mux):
//   reg_sel  register select: 0=data, 1=cs control, 2=status, 3=divider
//   wr, rd   single-cycle strobes; wr has priority when both are high
//   din      write data
//   dout     registered read data, valid the cycle after rd
//   cpuwait  high while a deferred data access is queued
//   busy     high while a byte is being shifted
// SD/SPI pins:
//   sd_cd (async card detect), sd_miso, sd_mosi, sd_sck, sd_cs (active-low)
// Debug:
//   dbg_shift  high while the engine FSM is in SHIFT
//
// Handshake: there is no valid/ready pair. A strobe (wr or rd) is taken on
// every clock edge it is high; a data access that cannot start at once is
// held in a one-deep queue and cpuwait is raised until the queue drains.
interface spi_master_nc_if #(
   parameter int NCS = 2
);
   logic [1:0]     reg_sel;
   logic           wr;
   logic           rd;
   logic [7:0]     din;
   logic [7:0]     dout;
   logic           cpuwait;
   logic           busy;
   logic           sd_cd;
   logic           sd_miso;
   logic           sd_mosi;
   logic           sd_sck;
   logic [NCS-1:0] sd_cs;
   logic           dbg_shift;

   // master: the SPI engine itself
   modport master (
      input  reg_sel, wr, rd, din, sd_cd, sd_miso,
      output dout, cpuwait, busy, sd_mosi, sd_sck, sd_cs, dbg_shift
   );

   // slave: the surrounding system (decoder, bus mux, card)
   modport slave (
      output reg_sel, wr, rd, din, sd_cd, sd_miso,
      input  dout, cpuwait, busy, sd_mosi, sd_sck, sd_cs, dbg_shift
   );
endinterface

// File: rtl/spi_master_nc.sv
// spi_master_nc - byte-wide SPI mode-0 master for SD cards with NCS chip
// selects, a runtime-programmable SCK divider, a one-deep deferred data
// access queue with CPU wait, read-triggered 0xFF exchange and status/overrun
// reporting.
//
// Ports:
//   clk28  system clock
//   rst    asynchronous active-high reset
//   bus    spi_master_nc_if.master (CPU register bus and SD pins)
//
// Parameters:
//   NCS        number of active-low chip selects (1..4)
//   DIV_W      divider register width (1..8)
//   DIV_RESET  divider value after reset
module spi_master_nc #(
   parameter int NCS       = 2,
   parameter int DIV_W     = 4,
   parameter int DIV_RESET = 0
) (
   input logic             clk28,
   input logic             rst,
   spi_master_nc_if.master bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             sck_q, sck_d;
   logic             mosi_q, mosi_d;
   logic [NCS-1:0]   cs_q, cs_d;
   logic [7:0]       dout_q, dout_d;
   logic [7:0]       rx_q, rx_d;
   logic [7:0]       shift_q, shift_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] div_act_q, div_act_d;
   logic [3:0]       tcnt_q, tcnt_d;
   logic             pend_q, pend_d;
   logic             pend_rd_q, pend_rd_d;
   logic [7:0]       pend_din_q, pend_din_d;
   logic             ovr_q, ovr_d;
   logic             cd1_q, cd2_q;

   logic             wr_data, rd_any, rd_data, access;
   logic             sck_tick, last_tick, start;
   logic [7:0]       new_tx, start_tx;

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      cs_d       = cs_q;
      dout_d     = dout_q;
      rx_d       = rx_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      div_act_d  = div_act_q;
      tcnt_d     = tcnt_q;
      pend_d     = pend_q;
      pend_rd_d  = pend_rd_q;
      pend_din_d = pend_din_q;
      ovr_d      = ovr_q;

      // wr wins over rd in the same cycle
      wr_data   = bus.wr && (bus.reg_sel == 2'd0);
      rd_any    = bus.rd && !bus.wr;
      rd_data   = rd_any && (bus.reg_sel == 2'd0);
      access    = wr_data || rd_data;
      new_tx    = wr_data ? bus.din : 8'hFF;
      sck_tick  = (state_q == SHIFT) && (cnt_q == '0);
      last_tick = sck_tick && (tcnt_q == 4'd15);
      start     = 1'b0;
      start_tx  = new_tx;

      if (bus.wr) begin
         case (bus.reg_sel)
            2'd1:    cs_d  = bus.din[NCS-1:0];
            2'd3:    div_d = bus.din[DIV_W-1:0];
            default: ;
         endcase
      end

      // Status read clears overrun here; a set later in this block wins.
      if (rd_any) begin
         case (bus.reg_sel)
            2'd1: dout_d = 8'(cs_q);
            2'd2: begin
               dout_d = {4'b0000, cd2_q, ovr_q, pend_q, busy_q};
               ovr_d  = 1'b0;
            end
            2'd3:    dout_d = 8'(div_q);
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (access) begin
               start = 1'b1;
               if (rd_data) dout_d = rx_q;
            end
         end
         SHIFT: begin
            cnt_d = cnt_q - 1'b1;
            if (sck_tick) begin
               cnt_d  = div_act_q;
               sck_d  = ~sck_q;
               tcnt_d = tcnt_q + 4'd1;
               // Rising edge samples MISO; after that shift the MSB is the
               // next bit to present on the following falling edge.
               if (!sck_q) shift_d = {shift_q[6:0], bus.sd_miso};
               else        mosi_d  = shift_q[7];
            end
            if (last_tick) begin
               rx_d    = shift_q;
               mosi_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
               // Chain the next transfer in the completing cycle so busy
               // never drops between back-to-back bytes.
               if (pend_q) begin
                  start    = 1'b1;
                  start_tx = pend_rd_q ? 8'hFF : pend_din_q;
                  pend_d   = 1'b0;
                  if (pend_rd_q) dout_d = shift_q;
                  if (access)    ovr_d  = 1'b1;
               end else if (access) begin
                  start = 1'b1;
                  if (rd_data) dout_d = shift_q;
               end
            end else if (access) begin
               if (pend_q) begin
                  ovr_d = 1'b1;
               end else begin
                  pend_d     = 1'b1;
                  pend_rd_d  = rd_data;
                  pend_din_d = bus.din;
               end
            end
         end
         default: ;
      endcase

      if (start) begin
         state_d   = SHIFT;
         busy_d    = 1'b1;
         sck_d     = 1'b0;
         mosi_d    = start_tx[7];
         shift_d   = start_tx;
         cnt_d     = div_q;
         div_act_d = div_q;
         tcnt_d    = 4'd0;
      end
   end

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b1;
         cs_q       <= '1;
         dout_q     <= 8'h00;
         rx_q       <= 8'h00;
         shift_q    <= 8'h00;
         cnt_q      <= '0;
         div_q      <= DIV_W'(DIV_RESET);
         div_act_q  <= DIV_W'(DIV_RESET);
         tcnt_q     <= 4'd0;
         pend_q     <= 1'b0;
         pend_rd_q  <= 1'b0;
         pend_din_q <= 8'h00;
         ovr_q      <= 1'b0;
         cd1_q      <= 1'b0;
         cd2_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         cs_q       <= cs_d;
         dout_q     <= dout_d;
         rx_q       <= rx_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         div_act_q  <= div_act_d;
         tcnt_q     <= tcnt_d;
         pend_q     <= pend_d;
         pend_rd_q  <= pend_rd_d;
         pend_din_q <= pend_din_d;
         ovr_q      <= ovr_d;
         // two-flop synchroniser for the asynchronous card detect
         cd1_q      <= bus.sd_cd;
         cd2_q      <= cd1_q;
      end
   end

   assign bus.dout      = dout_q;
   assign bus.cpuwait   = pend_q;
   assign bus.busy      = busy_q;
   assign bus.sd_mosi   = mosi_q;
   assign bus.sd_sck    = sck_q;
   assign bus.sd_cs     = cs_q;
   assign bus.dbg_shift = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_master_nc.sv
// tb_spi_master_nc - self-checking bench for spi_master_nc.
// A transaction-level model (elapsed-cycle counter per transfer, register
// copies, one-entry queue) predicts every output each cycle; directed
// scenarios add hand-computed literal expectations.
module tb_spi_master_nc;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_master_nc_if #(.NCS(2)) bus ();

   spi_master_nc #(.NCS(2), .DIV_W(4), .DIV_RESET(0)) u_dut (
      .clk28 (clk),
      .rst   (rst),
      .bus   (bus.master)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         m_active;
   int         m_k, m_d;
   logic [7:0] m_tx, m_mbyte, m_rx, m_dout, m_pend_din;
   bit         m_pend, m_pend_rd, m_ovr, m_cd1, m_cd2;
   logic [1:0] m_cs;
   logic [3:0] m_div;
   bit         force_en = 1'b0;
   logic [7:0] force_val = 8'h00;

   task automatic m_start(input logic [7:0] tx, input int d);
      m_active = 1'b1;
      m_k      = 0;
      m_d      = d;
      m_tx     = tx;
      m_mbyte  = force_en ? force_val : 8'($urandom);
      force_en = 1'b0;
   endtask

   initial begin
      bit         o_active, o_pend, o_ovr, o_cd2, done, w, r, acc_wr, acc_rd;
      logic [1:0] o_cs, sel;
      logic [3:0] o_div;
      logic [7:0] o_rx, d, ntx;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_active = 0; m_k = 0; m_d = 0; m_tx = 8'hFF; m_mbyte = 8'h00;
            m_rx = 8'h00; m_dout = 8'h00; m_pend = 0; m_pend_rd = 0;
            m_pend_din = 8'h00; m_ovr = 0; m_cd1 = 0; m_cd2 = 0;
            m_cs = 2'b11; m_div = 4'd0;
         end else begin
            o_active = m_active; o_pend = m_pend; o_ovr = m_ovr; o_cd2 = m_cd2;
            o_cs = m_cs; o_div = m_div; o_rx = m_rx;
            done = 0;
            if (m_active) begin
               m_k++;
               if (m_k == 16 * (m_d + 1)) begin
                  m_active = 0;
                  m_rx     = m_mbyte;
                  done     = 1;
               end
            end
            w = bus.wr; r = bus.rd && !bus.wr; sel = bus.reg_sel; d = bus.din;
            if (w && sel == 2'd1) m_cs = d[1:0];
            if (w && sel == 2'd3) m_div = d[3:0];
            if (r && sel == 2'd1) m_dout = {6'b0, o_cs};
            if (r && sel == 2'd2) begin
               m_dout = {4'b0, o_cd2, o_ovr, o_pend, o_active};
               m_ovr  = 0;
            end
            if (r && sel == 2'd3) m_dout = {4'b0, o_div};
            acc_wr = w && sel == 2'd0;
            acc_rd = r && sel == 2'd0;
            ntx    = acc_wr ? d : 8'hFF;
            if (!o_active) begin
               if (acc_wr || acc_rd) m_start(ntx, int'(o_div));
               if (acc_rd) m_dout = o_rx;
            end else if (done) begin
               if (o_pend) begin
                  m_start(m_pend_rd ? 8'hFF : m_pend_din, int'(o_div));
                  if (m_pend_rd) m_dout = m_rx;
                  m_pend = 0;
                  if (acc_wr || acc_rd) m_ovr = 1;
               end else if (acc_wr || acc_rd) begin
                  m_start(ntx, int'(o_div));
                  if (acc_rd) m_dout = m_rx;
               end
            end else if (acc_wr || acc_rd) begin
               if (o_pend) m_ovr = 1;
               else begin
                  m_pend = 1; m_pend_rd = acc_rd; m_pend_din = d;
               end
            end
            m_cd2 = m_cd1;
            m_cd1 = bus.sd_cd;
         end
      end
   end

   // ---------------- per-cycle compare + MISO drive ----------------
   logic [7:0] cap_mosi = 8'h00;
   int         run = 0, last_run = 0;
   logic       prev_sck = 1'b0;

   initial begin
      int   h;
      logic e_sck, e_mosi;
      bus.sd_miso = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            run = 0;
            prev_sck = 1'b0;
         end else begin
            if (m_active) begin
               h      = m_k / (m_d + 1);
               e_sck  = h[0];
               e_mosi = m_tx[7 - h / 2];
            end else begin
               h      = 0;
               e_sck  = 1'b0;
               e_mosi = 1'b1;
            end
            chk("busy",    bus.busy,      m_active);
            chk("dbg",     bus.dbg_shift, m_active);
            chk("sck",     bus.sd_sck,    e_sck);
            chk("mosi",    bus.sd_mosi,   e_mosi);
            chk("cs",      bus.sd_cs,     m_cs);
            chk("cpuwait", bus.cpuwait,   m_pend);
            chk("dout",    bus.dout,      m_dout);
            if (bus.sd_sck && !prev_sck) cap_mosi = {cap_mosi[6:0], bus.sd_mosi};
            prev_sck = bus.sd_sck;
            if (bus.busy) run++;
            else if (run != 0) begin
               last_run = run;
               run = 0;
            end
            bus.sd_miso = m_active ? m_mbyte[7 - h / 2] : 1'($urandom);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic bus_op(input logic w, input logic r, input logic [1:0] sel, input logic [7:0] d);
      @(negedge clk);
      bus.wr = w; bus.rd = r; bus.reg_sel = sel; bus.din = d;
      @(negedge clk);
      bus.wr = 1'b0; bus.rd = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (bus.busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_timeout: busy still 1 after %0d cycles", budget);
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      bus.wr = 0; bus.rd = 0; bus.reg_sel = 2'd0; bus.din = 8'h00; bus.sd_cd = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_dout", bus.dout, 8'h00);
      chk("rst_cs", bus.sd_cs, 2'b11);
      chk("rst_busy", bus.busy, 1'b0);

      // div=0: 0xA5 out, 0x3C in, 16 busy cycles
      force_val = 8'h3C; force_en = 1'b1;
      bus_op(1, 0, 2'd0, 8'hA5);
      wait_idle(100);
      chk("a_mosi", cap_mosi, 8'hA5);
      chk("a_len", 16'(last_run), 16'd16);
      bus_op(0, 1, 2'd0, 8'h00);
      chk("a_rx", bus.dout, 8'h3C);
      wait_idle(100);

      // div=2: queued read, overrun, chained transfers
      bus_op(1, 0, 2'd3, 8'h02);
      force_val = 8'h96; force_en = 1'b1;
      bus_op(1, 0, 2'd0, 8'h55);
      @(negedge clk);
      bus_op(0, 1, 2'd0, 8'h00);
      chk("b_wait", bus.cpuwait, 1'b1);
      bus_op(1, 0, 2'd0, 8'h77);
      bus_op(0, 1, 2'd2, 8'h00);
      chk("b_stat1", bus.dout, 8'h07);
      bus_op(0, 1, 2'd2, 8'h00);
      chk("b_stat2_ovr", bus.dout[2], 1'b0);
      wait_idle(400);
      chk("b_len", 16'(last_run), 16'd96);
      chk("b_rx", bus.dout, 8'h96);
      chk("b_wait_end", bus.cpuwait, 1'b0);

      // divider write mid-transfer, cs write mid-transfer
      bus_op(1, 0, 2'd3, 8'h01);
      bus_op(1, 0, 2'd0, 8'h5A);
      bus_op(1, 0, 2'd3, 8'h05);
      bus_op(1, 0, 2'd1, 8'h02);
      chk("c_cs", bus.sd_cs, 2'b10);
      wait_idle(200);
      chk("c_len1", 16'(last_run), 16'd32);
      bus_op(1, 0, 2'd0, 8'hC3);
      wait_idle(200);
      chk("c_len2", 16'(last_run), 16'd96);

      // rd and wr together: write wins, dout untouched
      bus_op(0, 1, 2'd1, 8'h00);
      chk("d_csrd", bus.dout, 8'h02);
      bus_op(1, 1, 2'd0, 8'h12);
      wait_idle(200);
      chk("d_mosi", cap_mosi, 8'h12);
      chk("d_dout", bus.dout, 8'h02);

      // randomized mix
      for (int i = 0; i < 400; i++) begin
         int         gap, kind;
         logic [1:0] sel;
         logic [7:0] d;
         gap = $urandom_range(0, 12);
         repeat (gap) @(negedge clk);
         if ($urandom_range(0, 7) == 0) bus.sd_cd = ~bus.sd_cd;
         sel  = 2'($urandom_range(0, 3));
         kind = $urandom_range(0, 9);
         d    = 8'($urandom);
         if (sel == 2'd3) d = d & 8'h03;
         if (kind <= 3)      bus_op(1, 0, sel, d);
         else if (kind <= 7) bus_op(0, 1, sel, d);
         else if (kind == 8) bus_op(1, 1, sel, d);
         else                @(negedge clk);
      end
      bus.sd_cd = 1'b0;
      repeat (2) begin
         wait_idle(2000);
         repeat (3) @(negedge clk);
      end

      // reset in the middle of a div=3 transfer
      bus_op(1, 0, 2'd1, 8'h00);
      bus_op(1, 0, 2'd3, 8'h03);
      bus_op(1, 0, 2'd0, 8'hE7);
      repeat (10) @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("r_sck", bus.sd_sck, 1'b0);
      chk("r_mosi", bus.sd_mosi, 1'b1);
      chk("r_cs", bus.sd_cs, 2'b11);
      chk("r_busy", bus.busy, 1'b0);
      chk("r_wait", bus.cpuwait, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      bus_op(0, 1, 2'd2, 8'h00);
      chk("r_stat", bus.dout, 8'h00);
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master_nc.md
Name: spi_master_nc

Overview:
- Parametrised successor to the DivMMC/Z-Controller SD SPI engine: a byte-wide SPI mode-0 master with NCS chip selects and a runtime-programmable SCK divider.
- Adds a one-deep deferred-request queue with CPU wait, read-triggered 0xFF exchange, and status/overrun reporting.
- Sits between the port decoder (which supplies reg_sel/rd/wr strobes) and the SD/SPI pins. The decoded read data and cpuwait go to the CPU bus mux.

Parameters:
- NCS, 2, number of active-low chip selects (1..4).
- DIV_W, 4, divider register width (1..8).
- DIV_RESET, 0, divider value after reset.

Ports:
- clk28  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- reg_sel  in  2  register select: 0=data, 1=cs control, 2=status, 3=divider.
- wr  in  1  single-cycle write strobe.
- rd  in  1  single-cycle read strobe.
- din  in  8  write data.
- dout  out  8  registered read data.
- cpuwait  out  1  CPU wait request.
- busy  out  1  transfer in progress.
- sd_cd  in  1  card detect, asynchronous.
- sd_miso  in  1  serial in.
- sd_mosi  out  1  serial out.
- sd_sck  out  1  serial clock.
- sd_cs  out  NCS  chip selects, active-low.

Behaviour:
- Reset values:
  - sd_sck=0, sd_mosi=1, sd_cs=all 1, busy=0, cpuwait=0, dout=0.
  - rx=0, div=DIV_RESET, pending=0, overrun=0.
  - Reset mid-transfer aborts immediately to IDLE with these values.
- States: IDLE, SHIFT.
- Start in IDLE:
  - wr to data loads tx=din.
  - rd to data sets dout<=rx and loads tx=8'hFF.
  - Next cycle: SHIFT, busy=1, sd_mosi=tx[7], half-period counter=div_active. div_active is captured from div at start.
- SHIFT:
  - Counter decrements every clk28. At 0 it reloads and sd_sck toggles.
  - Rising edge: shift reg <= {shift[6:0], sd_miso}.
  - Falling edge: sd_mosi <= next bit.
  - On the 16th toggle (sck returns low): rx<=shift, busy=0, sd_mosi=1, state IDLE.
  - busy is high for exactly 16*(div_active+1) cycles. div=0 gives sck=clk28/2.
- Access while busy:
  - A data-register wr/rd latches pending (kind plus din) and raises cpuwait the next cycle.
  - At completion the pending request starts in the same cycle busy would fall: busy stays 1, rd returns the just-completed rx in dout, pending=0, cpuwait=0.
  - A second data access while pending already holds is dropped and sets sticky overrun.
- rd and wr in the same cycle: wr wins, rd is ignored.
- cs control reg: wr sets sd_cs <= din[NCS-1:0] immediately, even mid-transfer. rd returns {zeros, sd_cs}.
- Divider reg:
  - wr sets div <= din[DIV_W-1:0].
  - A write during SHIFT affects only the next transfer.
  - rd returns zero-extended div.
- Status rd: dout = {4'b0, sd_cd_sync, overrun, pending, busy}. It clears overrun, unless overrun is set in the same cycle, in which case set wins.
- sd_cd is passed through a two-flop synchroniser; latency is 2 cycles.
- dout updates one cycle after rd and holds until the next rd.

Test Plan:
- Reset asserted mid-SHIFT with div=3 -> same-cycle sd_sck=0, sd_mosi=1, sd_cs=2'b11, busy=0. After release, status read = 0x00 (sd_cd=0).
- div=0, wr data 0xA5, MISO driven with 0x3C MSB-first on rising edges -> MOSI bits 1,0,1,0,0,1,0,1; busy high 16 cycles; subsequent rd data returns dout=0x3C and starts a 0xFF transfer.
- div=2, wr data 0x55 then rd data 3 cycles later -> cpuwait=1 until the first transfer ends. dout then holds the first transfer's rx, and the second transfer starts with no idle cycle (busy high 96 consecutive cycles).
- While busy with pending set, a third wr data -> dropped; status read shows 0x07; a second status read shows bit2=0.
- Write div=5 during SHIFT at div=1 -> current transfer lasts 32 cycles, next transfer 96 cycles. wr cs reg 0x02 mid-transfer -> sd_cs=2'b10 next cycle.
- Same-cycle rd and wr to data with din=0x12 -> transfer sends 0x12 and dout is unchanged.
